// File: rtl/sr_sem_pkg.sv
// Shared definitions for the SR-flag semaphore arbiter: op encodings and the
// round-robin winner search.
package sr_sem_pkg;

    localparam logic [1:0] OP_READ = 2'b00;
    localparam logic [1:0] OP_SET  = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;
    localparam logic [1:0] OP_TAS  = 2'b11;

    localparam int unsigned RR_W  = 32;
    localparam int unsigned RR_IW = 5;

    // First set bit at or above ptr, wrapping. Callers zero the bits above
    // their requester count, so wrapping over the full width is equivalent.
    function automatic logic [RR_W-1:0] rr_pick(input logic [RR_W-1:0]  req,
                                                input logic [RR_IW-1:0] ptr);
        logic [RR_W-1:0]  pick;
        logic [RR_IW-1:0] j;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < RR_W; k++) begin
            j = ptr + RR_IW'(k);
            if (!found && req[j]) begin
                pick[j] = 1'b1;
                found   = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/sr_flag_semaphore_arbiter_srff_cell.sv
// Single SR flag cell: s sets, r clears, neither holds. The driver never
// asserts both, so set simply takes priority here.
module srff_cell (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 1'b0;
        end else if (s) begin
            q <= 1'b1;
        end else if (r) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/sr_flag_semaphore_arbiter.sv
// Round-robin arbiter sharing a bank of SR flags as hardware semaphores,
// with per-flag ownership and a registered one-cycle response.
module sr_flag_semaphore_arbiter
    import sr_sem_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned N_FLAG = 8,
    parameter int unsigned IDX_W  = (N_FLAG > 1) ? $clog2(N_FLAG) : 1,
    parameter int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [2*N_REQ-1:0]       req_op,
    input  logic [IDX_W*N_REQ-1:0]   req_idx,
    output logic [N_REQ-1:0]         gnt,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_ok,
    output logic                     rsp_val,
    output logic [N_FLAG-1:0]        flags
);

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q [N_FLAG];
    logic              rsp_valid_q, rsp_ok_q, rsp_val_q;
    logic [ID_W-1:0]   rsp_id_q;

    logic [RR_W-1:0]   pick_c;
    logic [N_REQ-1:0]  gnt_c;
    logic              xfer_c;
    logic [ID_W-1:0]   win_c;
    logic [1:0]        op_c;
    logic [IDX_W-1:0]  idx_c;
    logic              idx_ok_c, cur_c;
    logic              set_c, clr_c, own_we_c, ok_c, val_c;
    logic [N_FLAG-1:0] s_vec, r_vec, q_vec;

    assign pick_c = rr_pick(RR_W'(req), RR_IW'(ptr_q));
    assign gnt_c  = rst ? pick_c[N_REQ-1:0] : '0;
    assign gnt    = gnt_c;
    assign xfer_c = |(req & gnt_c);

    if (N_REQ < RR_W) begin : g_pick_pad
        logic unused_pick;
        assign unused_pick = |pick_c[RR_W-1:N_REQ];
    end

    // Select the winner's id, op and index from the flattened request buses
    always_comb begin
        win_c = '0;
        op_c  = OP_READ;
        idx_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) begin
                win_c = ID_W'(i);
                op_c  = req_op[2*i +: 2];
                idx_c = req_idx[IDX_W*i +: IDX_W];
            end
        end
    end

    assign idx_ok_c = (32'(idx_c) < N_FLAG);
    assign cur_c    = idx_ok_c ? q_vec[idx_c] : 1'b0;

    // Op decode; set and clear are mutually exclusive by construction
    always_comb begin
        set_c    = 1'b0;
        clr_c    = 1'b0;
        own_we_c = 1'b0;
        ok_c     = 1'b0;
        val_c    = 1'b0;
        if (idx_ok_c) begin
            case (op_c)
                OP_READ: begin
                    ok_c  = 1'b1;
                    val_c = cur_c;
                end
                OP_SET: begin
                    set_c    = 1'b1;
                    own_we_c = 1'b1;
                    ok_c     = 1'b1;
                    val_c    = 1'b1;
                end
                OP_CLR: begin
                    if (!cur_c) begin
                        ok_c = 1'b1;
                    end else if (owner_q[idx_c] == win_c) begin
                        clr_c = 1'b1;
                        ok_c  = 1'b1;
                    end else begin
                        val_c = 1'b1;
                    end
                end
                default: begin
                    if (!cur_c) begin
                        set_c    = 1'b1;
                        own_we_c = 1'b1;
                        ok_c     = 1'b1;
                    end
                    val_c = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned f = 0; f < N_FLAG; f++) begin
            s_vec[f] = xfer_c & set_c & (idx_c == IDX_W'(f));
            r_vec[f] = xfer_c & clr_c & (idx_c == IDX_W'(f));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer_c) begin
            ptr_d = (win_c == ID_W'(N_REQ - 1)) ? '0 : win_c + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_ok_q    <= 1'b0;
            rsp_val_q   <= 1'b0;
            for (int unsigned f = 0; f < N_FLAG; f++) begin
                owner_q[f] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= xfer_c;
            if (xfer_c) begin
                rsp_id_q  <= win_c;
                rsp_ok_q  <= ok_c;
                rsp_val_q <= val_c;
                if (own_we_c) begin
                    owner_q[idx_c] <= win_c;
                end
            end
        end
    end

    for (genvar f = 0; f < N_FLAG; f++) begin : g_cell
        srff_cell u_cell (
            .clk (clk),
            .rst (rst),
            .s   (s_vec[f]),
            .r   (r_vec[f]),
            .q   (q_vec[f])
        );
    end

    assign flags     = q_vec;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_ok    = rsp_ok_q;
    assign rsp_val   = rsp_val_q;

endmodule

// File: tb/tb_sr_flag_semaphore_arbiter.sv
// Scoreboard bench for the semaphore arbiter: directed scenarios followed by
// randomized request traffic checked against a behavioural model.
module tb_sr_flag_semaphore_arbiter;

    localparam int N = 4;
    localparam int F = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [7:0]    req_op;
    logic [11:0]   req_idx;
    logic [3:0]    gnt;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic          rsp_ok;
    logic          rsp_val;
    logic [7:0]    flags;

    sr_flag_semaphore_arbiter #(.N_REQ(N), .N_FLAG(F)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_ok    (rsp_ok),
        .rsp_val   (rsp_val),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         id;
        bit         ok;
        bit         val;
        logic [7:0] fl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sr_viol = 0;
    bit   prev_rst_low = 1'b0;

    // Reference model state
    bit   mf[F];
    int   mown[F];
    int   mptr = 0;

    // Requester-side pending requests for random traffic
    bit         pend[N];
    logic [1:0] pop[N];
    logic [2:0] pix[N];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ((dut.s_vec & dut.r_vec) != '0) sr_viol++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the oldest expected response whenever one appears
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_latency", cyc, e.due);
                chk("rsp_id", 32'(rsp_id), e.id);
                chk("rsp_ok", 32'(rsp_ok), 32'(e.ok));
                chk("rsp_val", 32'(rsp_val), 32'(e.val));
                chk("flags", 32'(flags), 32'(e.fl));
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            chk("rsp_missing", 32'(rsp_valid), 32'd1);
            void'(sbq.pop_front());
        end
    end

    // One clock of stimulus; model predicts grant and queues the response
    task automatic step(input bit r, input logic [3:0] rq, input logic [7:0] ov,
                        input logic [11:0] iv, output int w);
        logic [3:0] eg;
        exp_t       e;
        int         o, ix;
        rst = r; req = rq; req_op = ov; req_idx = iv;
        @(negedge clk);
        if (prev_rst_low) begin
            chk("reset_flags", 32'(flags), 32'd0);
            chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset_rsp_fields", {29'd0, rsp_id, rsp_ok}, 32'd0);
            chk("reset_rsp_val", 32'(rsp_val), 32'd0);
        end
        w  = -1;
        eg = '0;
        if (r) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (w < 0 && rq[j]) w = j;
            end
        end
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (!r) begin
            for (int f = 0; f < F; f++) begin mf[f] = 1'b0; mown[f] = 0; end
            mptr = 0;
        end else if (w >= 0) begin
            o  = int'(ov[2*w +: 2]);
            ix = int'(iv[3*w +: 3]);
            e.ok = 1'b0;
            case (o)
                0: e.ok = 1'b1;
                1: begin mf[ix] = 1'b1; mown[ix] = w; e.ok = 1'b1; end
                2: begin
                    if (!mf[ix]) e.ok = 1'b1;
                    else if (mown[ix] == w) begin mf[ix] = 1'b0; e.ok = 1'b1; end
                end
                default: begin
                    if (!mf[ix]) begin mf[ix] = 1'b1; mown[ix] = w; e.ok = 1'b1; end
                end
            endcase
            e.val = mf[ix];
            e.id  = w;
            e.due = cyc + 1;
            for (int f = 0; f < F; f++) e.fl[f] = mf[f];
            sbq.push_back(e);
            mptr = (w + 1) % N;
        end
        prev_rst_low = !r;
        @(posedge clk);
        #1;
    endtask

    // All active requesters share one op and index
    task automatic go(input bit r, input logic [3:0] rq, input logic [1:0] o, input logic [2:0] ix);
        int w;
        step(r, rq, {4{o}}, {4{ix}}, w);
    endtask

    initial begin
        int         w;
        logic [3:0]  rq;
        logic [7:0]  ov;
        logic [11:0] iv;
        bit          r;

        rst = 1'b0; req = '0; req_op = '0; req_idx = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pop[i] = '0; pix[i] = '0; end
        @(posedge clk);
        #1;

        // Reset with all requests present
        go(1'b0, 4'b1111, 2'b11, 3'd1);
        go(1'b0, 4'b1111, 2'b11, 3'd1);

        // Held READs rotate through all requesters
        for (int i = 0; i < 5; i++) go(1'b1, 4'b1111, 2'b00, 3'd0);

        // TAS contention on idx3 right after reset
        go(1'b0, 4'b0000, 2'b00, 3'd0);
        go(1'b1, 4'b0011, 2'b11, 3'd3);
        go(1'b1, 4'b0010, 2'b11, 3'd3);

        // CLR by non-owner fails, by owner succeeds
        go(1'b1, 4'b0010, 2'b10, 3'd3);
        go(1'b1, 4'b0001, 2'b10, 3'd3);

        // SET, failing TAS, READ on idx5
        go(1'b1, 4'b0100, 2'b01, 3'd5);
        go(1'b1, 4'b1000, 2'b11, 3'd5);
        go(1'b1, 4'b1000, 2'b00, 3'd5);

        // Grant then reset; next grant goes to the lowest requester
        go(1'b1, 4'b0001, 2'b11, 3'd2);
        go(1'b0, 4'b1111, 2'b11, 3'd2);
        go(1'b1, 4'b0110, 2'b00, 3'd2);
        go(1'b1, 4'b0000, 2'b00, 3'd0);

        // Random traffic with held, dropped and contending requests
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < N; i++) begin
                if (pend[i]) begin
                    if ($urandom_range(0, 15) == 0) pend[i] = 1'b0;
                end else if ($urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pop[i]  = 2'($urandom_range(0, 3));
                    pix[i]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                          : 3'($urandom_range(0, 2));
                end
            end
            for (int i = 0; i < N; i++) begin
                rq[i]          = pend[i];
                ov[2*i +: 2]   = pop[i];
                iv[3*i +: 3]   = pix[i];
            end
            step(r, rq, ov, iv, w);
            if (!r) begin
                for (int i = 0; i < N; i++) pend[i] = 1'b0;
            end else if (w >= 0) begin
                pend[w] = 1'b0;
            end
        end

        for (int i = 0; i < 3; i++) go(1'b1, 4'b0000, 2'b00, 3'd0);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        chk("sr_conflict", 32'(sr_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
